// File: rtl/fetch_pc_controller.sv
// IF-stage program counter owner: prioritises overwrite/branch/jump redirects, halt and stall,
// handshakes instruction fetches and flushes IF/ID. Optional macro: FETCH_REDIRECT_COUNT_EN.
module fetch_pc_controller #(
    parameter int                   DataWidth   = 16,
    parameter logic [DataWidth-1:0] ResetVector = '0,
    parameter int                   CountWidth  = 16
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  TakeBranch,
    input  logic [DataWidth-1:0]  BranchTarget,
    input  logic                  TakeJump,
    input  logic [DataWidth-1:0]  JumpTarget,
    input  logic                  PCOverwrite,
    input  logic [DataWidth-1:0]  OverwriteAddress,
    input  logic                  Halt,
    input  logic                  Resume,
    input  logic                  Stall,
    input  logic                  IMemReady,
    output logic [DataWidth-1:0]  PC,
    output logic [DataWidth-1:0]  PCPlusOne,
    output logic                  IMemReq,
    output logic                  FetchValid,
    output logic                  FlushIFID,
    output logic                  Halted,
    output logic [1:0]            DbgState
`ifdef FETCH_REDIRECT_COUNT_EN
    ,
    output logic [CountWidth-1:0] RedirectCount
`endif
);

    // DbgState encoding: 0 = BOOT, 1 = RUN, 2 = HALTED.
    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t               r_state;
    logic [DataWidth-1:0] r_pc;
    logic                 r_imem_req;
    logic                 r_halted;

    logic                 w_in_run;
    logic                 w_in_halted;
    logic                 w_run_redirect;
    logic                 w_flush;
    logic                 w_fetch_valid;
    logic [DataWidth-1:0] w_pc_plus_one;

    assign w_in_run       = (r_state == ST_RUN);
    assign w_in_halted    = (r_state == ST_HALTED);
    assign w_run_redirect = PCOverwrite | TakeBranch | TakeJump;
    // In HALTED only an overwrite can redirect; branch/jump are ignored there.
    assign w_flush        = (w_in_run & w_run_redirect) | (w_in_halted & PCOverwrite);
    assign w_fetch_valid  = w_in_run & IMemReady & ~Stall & ~Halt & ~w_run_redirect;
    assign w_pc_plus_one  = r_pc + DataWidth'(1);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= ST_BOOT;
            r_pc       <= ResetVector;
            r_imem_req <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state    <= ST_RUN;
                    r_imem_req <= 1'b1;
                end
                ST_RUN: begin
                    if (PCOverwrite) begin
                        r_pc <= OverwriteAddress;
                    end else if (TakeBranch) begin
                        r_pc <= BranchTarget;
                    end else if (TakeJump) begin
                        r_pc <= JumpTarget;
                    end else if (Halt) begin
                        r_state    <= ST_HALTED;
                        r_imem_req <= 1'b0;
                        r_halted   <= 1'b1;
                    end else if (!Stall && IMemReady) begin
                        // A stalled cycle drops returned data, so the same PC is refetched.
                        r_pc <= w_pc_plus_one;
                    end
                end
                ST_HALTED: begin
                    if (PCOverwrite) begin
                        r_pc       <= OverwriteAddress;
                        r_state    <= ST_RUN;
                        r_imem_req <= 1'b1;
                        r_halted   <= 1'b0;
                    end else if (Resume) begin
                        r_state    <= ST_RUN;
                        r_imem_req <= 1'b1;
                        r_halted   <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_BOOT;
                    r_imem_req <= 1'b0;
                    r_halted   <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_REDIRECT_COUNT_EN
    logic [CountWidth-1:0] r_redirect_count;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_redirect_count <= '0;
        end else if (w_flush && (r_redirect_count != {CountWidth{1'b1}})) begin
            r_redirect_count <= r_redirect_count + CountWidth'(1);
        end
    end

    assign RedirectCount = r_redirect_count;
`endif

    assign PC         = r_pc;
    assign PCPlusOne  = w_pc_plus_one;
    assign IMemReq    = r_imem_req;
    assign Halted     = r_halted;
    assign FetchValid = w_fetch_valid;
    assign FlushIFID  = w_flush;
    assign DbgState   = r_state;

endmodule
